// File: rtl/kyber_ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kyber_ntt_pkg
// Purpose  : Shared constants, mode encodings and FSM state encoding for the
//            Kyber NTT/INTT address generator.
// Revision : 1.0 - initial release
// ============================================================================
package kyber_ntt_pkg;

  localparam int ADDR_W          = 7;
  localparam int N_WORDS         = 128;
  localparam int LAYERS          = 7;
  localparam int BEATS_PER_LAYER = 32;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ntt_butterfly_index.sv
`default_nettype none
// ============================================================================
// Module   : ntt_butterfly_index
// Purpose  : Combinational map from butterfly index, layer and direction to
//            the top/bottom coefficient addresses and the zeta index.
//            Half-distance len is a power of two, so all division and modulo
//            reduce to shifts and masks.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_butterfly_index
  import kyber_ntt_pkg::*;
(
  input  logic [ADDR_W-2:0] b,
  input  logic [2:0]        layer,
  input  logic              mode,
  output logic [ADDR_W-1:0] addr_top,
  output logic [ADDR_W-1:0] addr_bot,
  output logic [ADDR_W-1:0] twiddle
);

  logic [2:0]        shamt;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] b_ext;
  logic [ADDR_W-1:0] quot;
  logic [ADDR_W-1:0] base;

  // Derive len = 2^shamt, then split b into group number and offset in group
  always_comb begin
    shamt    = (mode == MODE_INTT) ? layer : (3'd6 - layer);
    len      = 7'd1 << shamt;
    b_ext    = {1'b0, b};
    quot     = b_ext >> shamt;
    base     = (quot << (shamt + 3'd1)) | (b_ext & (len - 7'd1));
    addr_top = base;
    // bit 'shamt' of base is always clear, so OR equals add
    addr_bot = base | len;
    if (mode == MODE_INTT) begin
      twiddle = 7'((8'd128 >> layer) - 8'd1 - {1'b0, quot});
    end else begin
      twiddle = (7'd1 << layer) + quot;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ntt_address_generator.sv
`default_nettype none
// ============================================================================
// Module   : ntt_address_generator
// Purpose  : Sequences the 7 layers x 32 beats of a Kyber NTT/INTT, issuing
//            two butterflies (four coefficient addresses, two zeta indices)
//            per beat with registered outputs.
// Options  : NTT_STAGE_GAP_EN - insert STAGE_GAP bubble cycles between layers
// Revision : 1.0 - initial release
// ============================================================================
module ntt_address_generator #(
  parameter int ADDR_W    = 7,
  parameter int LAYERS    = 7,
  parameter int STAGE_GAP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              stall,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] old_address_0,
  output logic [ADDR_W-1:0] old_address_1,
  output logic [ADDR_W-1:0] old_address_2,
  output logic [ADDR_W-1:0] old_address_3,
  output logic [ADDR_W-1:0] twiddle_addr_0,
  output logic [ADDR_W-1:0] twiddle_addr_1,
  output logic [2:0]        layer,
  output logic              busy,
  output logic              done
);
  import kyber_ntt_pkg::*;

  localparam logic [2:0] LAST_LAYER = 3'(LAYERS - 1);
  localparam logic [4:0] LAST_BEAT  = 5'(BEATS_PER_LAYER - 1);

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        layer_q, layer_d;
  logic              mode_q, mode_d;
  logic              addr_valid_q, addr_valid_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d, addr3_q, addr3_d;
  logic [ADDR_W-1:0] tw0_q, tw0_d, tw1_q, tw1_d;
  logic              load_beat;

  logic [ADDR_W-1:0] bf_a_top, bf_a_bot, bf_a_tw;
  logic [ADDR_W-1:0] bf_b_top, bf_b_bot, bf_b_tw;

`ifdef NTT_STAGE_GAP_EN
  localparam int              GAP_W    = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

  // Butterflies are evaluated on the next-beat coordinates so the result can
  // be registered in the same edge that advances the counters.
  ntt_butterfly_index u_bf_a (
    .b        ({cnt_d, 1'b0}),
    .layer    (layer_d),
    .mode     (mode_d),
    .addr_top (bf_a_top),
    .addr_bot (bf_a_bot),
    .twiddle  (bf_a_tw)
  );

  ntt_butterfly_index u_bf_b (
    .b        ({cnt_d, 1'b1}),
    .layer    (layer_d),
    .mode     (mode_d),
    .addr_top (bf_b_top),
    .addr_bot (bf_b_bot),
    .twiddle  (bf_b_tw)
  );

  // Next-state, counter and output-register update logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    layer_d      = layer_q;
    mode_d       = mode_q;
    addr_valid_d = addr_valid_q;
    busy_d       = busy_q;
    load_beat    = 1'b0;
`ifdef NTT_STAGE_GAP_EN
    gap_cnt_d    = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // start is honoured even under stall; beat 0 is then held
        if (start) begin
          state_d      = ST_RUN;
          cnt_d        = 5'd0;
          layer_d      = 3'd0;
          mode_d       = mode;
          addr_valid_d = 1'b1;
          busy_d       = 1'b1;
          load_beat    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (cnt_q != LAST_BEAT) begin
            cnt_d     = cnt_q + 5'd1;
            load_beat = 1'b1;
          end else if (layer_q != LAST_LAYER) begin
`ifdef NTT_STAGE_GAP_EN
            state_d      = ST_GAP;
            addr_valid_d = 1'b0;
            gap_cnt_d    = '0;
`else
            layer_d   = layer_q + 3'd1;
            cnt_d     = 5'd0;
            load_beat = 1'b1;
`endif
          end else begin
            state_d      = ST_DONE;
            addr_valid_d = 1'b0;
            busy_d       = 1'b0;
          end
        end
      end
`ifdef NTT_STAGE_GAP_EN
      ST_GAP: begin
        if (!stall) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d      = ST_RUN;
            layer_d      = layer_q + 3'd1;
            cnt_d        = 5'd0;
            addr_valid_d = 1'b1;
            load_beat    = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
`endif
      ST_DONE: begin
        if (!stall) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    addr0_d = load_beat ? bf_a_top : addr0_q;
    addr1_d = load_beat ? bf_a_bot : addr1_q;
    addr2_d = load_beat ? bf_b_top : addr2_q;
    addr3_d = load_beat ? bf_b_bot : addr3_q;
    tw0_d   = load_beat ? bf_a_tw  : tw0_q;
    tw1_d   = load_beat ? bf_b_tw  : tw1_q;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      layer_q      <= '0;
      mode_q       <= MODE_NTT;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      addr0_q      <= '0;
      addr1_q      <= '0;
      addr2_q      <= '0;
      addr3_q      <= '0;
      tw0_q        <= '0;
      tw1_q        <= '0;
`ifdef NTT_STAGE_GAP_EN
      gap_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      layer_q      <= layer_d;
      mode_q       <= mode_d;
      addr_valid_q <= addr_valid_d;
      busy_q       <= busy_d;
      addr0_q      <= addr0_d;
      addr1_q      <= addr1_d;
      addr2_q      <= addr2_d;
      addr3_q      <= addr3_d;
      tw0_q        <= tw0_d;
      tw1_q        <= tw1_d;
`ifdef NTT_STAGE_GAP_EN
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  assign addr_valid     = addr_valid_q;
  assign old_address_0  = addr0_q;
  assign old_address_1  = addr1_q;
  assign old_address_2  = addr2_q;
  assign old_address_3  = addr3_q;
  assign twiddle_addr_0 = tw0_q;
  assign twiddle_addr_1 = tw1_q;
  assign layer          = layer_q;
  assign busy           = busy_q;
  // DONE is held while stalled; the pulse is shown only on the releasing cycle
  assign done           = (state_q == ST_DONE) && !stall;

endmodule
`default_nettype wire
